ftoi_pipe: RTL and testbench
============================

# ftoi_pipe

Two-stage pipelined float-to-integer converter with valid/ready handshakes and a destination-register tag. It sits between FPU issue and integer writeback in the FPU execution path. It converts IEEE-754 single-precision operands to signed 32-bit integers with truncation toward zero and saturation. It supports backpressure and pipeline flush.

## Interface
- TAG_W, default 6: width of the destination-register tag carried alongside each operand.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; kills all in-flight operations.
- in_valid  in  1  operand offered.
- in_ready  out  1  block accepts the operand this cycle.
- in_x  in  32  single-precision operand.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result this cycle.
- out_y  out  32  signed integer result.
- out_tag  out  TAG_W  tag of the result.
- out_nv  out  1  invalid flag; present only with FTOI_FLAGS_EN.
- out_nx  out  1  inexact flag; present only with FTOI_FLAGS_EN.

## Operation
- Field split: s = x[31], e = x[30:23], m = x[22:0].
- Stage 1 (decode), registered:
  - s.
  - class: ZERO if e <= 126; SAT if e >= 158; NORM otherwise.
  - shift amount sh = (e - 127)[4:0].
  - mantissa {1, m}.
  - tag.
- Stage 2 (shift/negate), registered:
  - NORM: mag = ({1, m} << sh) >> 23, 31 bits; y = s ? -{0, mag} : {0, mag} (two's complement).
  - ZERO: y = 0, including denormals and -0.
  - SAT: y = s ? 0x80000000 : 0x7FFFFFFF. NaN and infinity saturate by sign bit.
- Pipeline control, per stage:
  - A stage advances when its downstream slot is empty or is draining this cycle.
  - in_ready = !s1_valid || s1_advances. This is a combinational path from out_ready; no skid buffer.
  - Results leave in issue order. No reordering. No bubbles are required under continuous flow.
- flush: s1_valid and s2_valid clear on the next edge.
  - The in_valid of the flush cycle is not accepted; in_ready is forced to 0 during flush.
  - out_valid may be high in the flush cycle. Any handshake completing in that cycle counts as done.

## Timing
- Reset values: out_valid=0, out_y=0, out_tag=0, out_nv=0, out_nx=0, in_ready=1. All internal valid bits are 0.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+1, provided out_ready has not stalled.
- Throughput: one conversion per cycle when out_ready stays 1.
- Stall: while out_valid && !out_ready, out_y, out_tag and the flags hold stable. Stage 1 fills, then in_ready drops.
- Simultaneous accept and drain on a full pipe: both stages shift in the same edge with no loss.
- Reset asserted mid-operation: all valids clear immediately (asynchronously). In-flight data is discarded.

## Configuration
- FTOI_FLAGS_EN defined:
  - out_nv = 1 for NaN. It is also 1 when e >= 158, except for x = 0xCF000000, which is exactly -2^31 and valid.
  - out_nx = 1 when a NORM operation discards nonzero fraction bits. It is also 1 for a ZERO-class input with e != 0 or m != 0.
  - Both flags are pipelined with the data.
- FTOI_FLAGS_EN undefined: out_nv and out_nx ports are absent. No flag logic is generated.

## Test plan
- Basic values, streamed back-to-back with out_ready=1:
  - 0x3FC00000 (1.5) -> 0x00000001.
  - 0xC0200000 (-2.5) -> 0xFFFFFFFE.
  - 0x3F000000 (0.5) -> 0.
  - 0x80000000 -> 0.
  - Each result emerges 2 cycles after acceptance, with tags in order.
- Saturation:
  - 0x4F000000 -> 0x7FFFFFFF (nv=1).
  - 0xCF000000 -> 0x80000000 (nv=0).
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF (nv=1).
  - 0x4EFFFFFF -> 0x7FFFFF80.
- Backpressure:
  - Issue 4 operands with out_ready=0 for 5 cycles.
  - Expect in_ready to fall after 2 acceptances and out_y to hold stable.
  - Release out_ready: all 4 results drain in order on consecutive cycles.
- Flush:
  - Fill both stages, then assert flush for 1 cycle while in_valid=1.
  - Next cycle: out_valid=0, and neither the flushed operands nor the offered one ever appear.
- Reset mid-stream:
  - Drop rstn between clock edges with the pipe full.
  - Expect out_valid=0 and out_y=0 immediately, and in_ready=1 after release.
- Flags (FTOI_FLAGS_EN):
  - 0x3FC00000 -> nx=1.
  - 0x40000000 -> nx=0, y=2.
  - 0x00000001 -> y=0, nx=1.

Source files
------------

// File: rtl/ftoi_pipe.sv
// Two-stage pipelined float-to-int converter: IEEE-754 single -> signed 32-bit, truncating, saturating.
// Define FTOI_FLAGS_EN to add the out_nv / out_nx exception flag ports.
module ftoi_pipe #(
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_y,
   output logic [TAG_W-1:0] out_tag
`ifdef FTOI_FLAGS_EN
   ,
   output logic             out_nv,
   output logic             out_nx
`endif
);

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_SAT  = 2'd2
   } cls_e;

   logic             w_s;
   logic [7:0]       w_e;
   logic [22:0]      w_m;
   cls_e             w_cls;
   logic             w_s1_adv;
   logic             w_in_acc;
   logic             w_s2_load;

   logic             r_s1_valid;
   logic             r_s1_s;
   cls_e             r_s1_cls;
   logic [4:0]       r_s1_sh;
   logic [23:0]      r_s1_mant;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [31:0]      r_s2_y;
   logic [TAG_W-1:0] r_s2_tag;

   logic [53:0]      w_wide;
   logic [30:0]      w_mag;
   logic             w_frac_nz;
   logic [31:0]      w_norm_y;
   logic [31:0]      w_y;

   assign w_s = in_x[31];
   assign w_e = in_x[30:23];
   assign w_m = in_x[22:0];

   always_comb begin
      w_cls = CLS_NORM;
      if (w_e <= 8'd126)
         w_cls = CLS_ZERO;
      else if (w_e >= 8'd158)
         w_cls = CLS_SAT;
   end

   // Stage 1 moves on when stage 2 is empty or its result is taken this cycle.
   assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready  = !flush && (!r_s1_valid || w_s1_adv);
   assign w_in_acc  = in_valid && in_ready;
   assign w_s2_load = w_s1_adv && !flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid <= 1'b0;
         r_s1_s     <= 1'b0;
         r_s1_cls   <= CLS_ZERO;
         r_s1_sh    <= 5'd0;
         r_s1_mant  <= 24'd0;
         r_s1_tag   <= '0;
      end else begin
         if (flush)
            r_s1_valid <= 1'b0;
         else if (w_in_acc)
            r_s1_valid <= 1'b1;
         else if (w_s1_adv)
            r_s1_valid <= 1'b0;
         if (w_in_acc) begin
            r_s1_s    <= w_s;
            r_s1_cls  <= w_cls;
            r_s1_sh   <= 5'(w_e - 8'd127);
            r_s1_mant <= {1'b1, w_m};
            r_s1_tag  <= in_tag;
         end
      end
   end

   // Largest NORM shift is 30, so a 54-bit field holds the 24-bit mantissa without loss.
   assign w_wide    = {30'd0, r_s1_mant} << r_s1_sh;
   assign w_mag     = w_wide[53:23];
   assign w_frac_nz = |w_wide[22:0];
   assign w_norm_y  = r_s1_s ? (32'd0 - {1'b0, w_mag}) : {1'b0, w_mag};

   always_comb begin
      w_y = 32'd0;
      case (r_s1_cls)
         CLS_NORM: w_y = w_norm_y;
         CLS_SAT:  w_y = r_s1_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
         default:  w_y = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s2_valid <= 1'b0;
         r_s2_y     <= 32'd0;
         r_s2_tag   <= '0;
      end else begin
         if (flush)
            r_s2_valid <= 1'b0;
         else if (w_s1_adv)
            r_s2_valid <= 1'b1;
         else if (out_ready)
            r_s2_valid <= 1'b0;
         if (w_s2_load) begin
            r_s2_y   <= w_y;
            r_s2_tag <= r_s1_tag;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_y     = r_s2_y;
   assign out_tag   = r_s2_tag;

`ifdef FTOI_FLAGS_EN
   logic w_nv_in;
   logic w_znx_in;
   logic r_s1_nv;
   logic r_s1_znx;
   logic r_s2_nv;
   logic r_s2_nx;
   logic w_nx;

   // -2^31 is the one SAT-class value that is exactly representable.
   assign w_nv_in  = ((w_e == 8'hFF) && (w_m != 23'd0)) ||
                     ((w_e >= 8'd158) && (in_x != 32'hCF00_0000));
   assign w_znx_in = (w_e != 8'd0) || (w_m != 23'd0);

   always_comb begin
      w_nx = 1'b0;
      case (r_s1_cls)
         CLS_NORM: w_nx = w_frac_nz;
         CLS_ZERO: w_nx = r_s1_znx;
         default:  w_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_nv  <= 1'b0;
         r_s1_znx <= 1'b0;
         r_s2_nv  <= 1'b0;
         r_s2_nx  <= 1'b0;
      end else begin
         if (w_in_acc) begin
            r_s1_nv  <= w_nv_in;
            r_s1_znx <= w_znx_in;
         end
         if (w_s2_load) begin
            r_s2_nv <= r_s1_nv;
            r_s2_nx <= w_nx;
         end
      end
   end

   assign out_nv = r_s2_nv;
   assign out_nx = r_s2_nx;
`else
   logic w_unused_frac;
   assign w_unused_frac = w_frac_nz;
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: vector table, random stream with a real-number model,
// then backpressure, flush and mid-stream reset sequences, all scored through one queue.
module tb_ftoi_pipe;
   localparam int TAG_W = 6;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_x = 32'd0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_y;
   logic [TAG_W-1:0] out_tag;
`ifdef FTOI_FLAGS_EN
   logic             out_nv;
   logic             out_nx;
`endif

   ftoi_pipe #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_tag   (out_tag)
`ifdef FTOI_FLAGS_EN
      ,
      .out_nv    (out_nv),
      .out_nx    (out_nx)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        nv;
      logic        nx;
   } vec_t;

   typedef struct {
      logic [31:0]      y;
      logic [TAG_W-1:0] tag;
      logic             nv;
      logic             nx;
      int               cyc;
      bit               lat;
   } exp_t;

   exp_t             sb[$];
   exp_t             e;
   int               pop_log[$];
   int               n_cmp = 0;
   int               n_bad = 0;
   int               cyc = 0;
   int               acc_total = 0;
   logic [31:0]      cur_y = 32'd0;
   logic             cur_nv = 1'b0;
   logic             cur_nx = 1'b0;
   bit               cur_lat = 1'b0;
   logic [TAG_W-1:0] tag_ctr = '0;
   vec_t             tbl[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Independent reference: widen to double, truncate with $rtoi, detect range/inexact.
   function automatic void model(input logic [31:0] x, output logic [31:0] y,
                                 output logic nv, output logic nx);
      logic [7:0]  ex;
      logic [22:0] mx;
      logic [63:0] db;
      real         r;
      int          yi;
      ex = x[30:23];
      mx = x[22:0];
      nv = 1'b0;
      nx = 1'b0;
      y  = 32'd0;
      if (ex == 8'hFF) begin
         nv = 1'b1;
         y  = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (ex == 8'd0) begin
         nx = (mx != 23'd0);
      end else begin
         db = {x[31], 11'(ex) + 11'd896, mx, 29'd0};
         r  = $bitstoreal(db);
         if (r >= 2147483648.0) begin
            nv = 1'b1;
            y  = 32'h7FFF_FFFF;
         end else if (r < -2147483648.0) begin
            nv = 1'b1;
            y  = 32'h8000_0000;
         end else if (r == -2147483648.0) begin
            y = 32'h8000_0000;
         end else begin
            yi = $rtoi(r);
            y  = 32'(yi);
            nx = ($itor(yi) != r);
         end
      end
   endfunction

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rstn) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got y=%h tag=%h want no output", out_y, out_tag);
            end else begin
               e = sb.pop_front();
               $display("out: y=%h tag=%h want y=%h tag=%h", out_y, out_tag, e.y, e.tag);
               check("out_y", 64'(out_y), 64'(e.y));
               check("out_tag", 64'(out_tag), 64'(e.tag));
`ifdef FTOI_FLAGS_EN
               check("out_nv", 64'(out_nv), 64'(e.nv));
               check("out_nx", 64'(out_nx), 64'(e.nx));
`endif
               if (e.lat)
                  check("latency", 64'(cyc - e.cyc), 64'd2);
               pop_log.push_back(cyc);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{y: cur_y, tag: in_tag, nv: cur_nv, nx: cur_nx, cyc: cyc, lat: cur_lat});
            acc_total++;
         end
      end
   end

   // Offer one operand and hold it until accepted; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic nv,
                       input logic nx, input bit lat);
      int  budget;
      bit  acc;
      in_valid = 1'b1;
      in_x     = x;
      in_tag   = tag_ctr;
      cur_y    = y;
      cur_nv   = nv;
      cur_nx   = nx;
      cur_lat  = lat;
      tag_ctr  = tag_ctr + 1'b1;
      budget   = 60;
      acc      = 1'b0;
      while (!acc && budget > 0) begin
         @(negedge clk);
         acc = in_ready;
         budget--;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got no in_ready want accept of x=%h", x);
      end
   endtask

   task automatic wait_drain();
      int budget;
      budget = 60;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rx, ry;
      logic        rnv, rnx;
      logic [31:0] held;
      bit          have, dropped;
      int          base;

      tbl[0]  = '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1};
      tbl[1]  = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1};
      tbl[2]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1};
      tbl[3]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
      tbl[4]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
      tbl[5]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0};
      tbl[6]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
      tbl[7]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0};
      tbl[8]  = '{32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0};
      tbl[9]  = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
      tbl[10] = '{32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
      tbl[11] = '{32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0};
      tbl[12] = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0};
      tbl[13] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0};
      tbl[14] = '{32'h3F7F_FFFF, 32'h0000_0000, 1'b0, 1'b1};
      tbl[15] = '{32'hFFC0_0000, 32'h8000_0000, 1'b1, 1'b0};

      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_y", 64'(out_y), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef FTOI_FLAGS_EN
      check("rst_out_nv", 64'(out_nv), 64'd0);
      check("rst_out_nx", 64'(out_nx), 64'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Table vectors, back-to-back with out_ready held high.
      for (int i = 0; i < 16; i++)
         send(tbl[i].x, tbl[i].y, tbl[i].nv, tbl[i].nx, 1'b1);
      wait_drain();

      // Random stream around the NORM/SAT/ZERO boundaries.
      for (int i = 0; i < 40; i++) begin
         rx = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 162)), 23'($urandom)};
         model(rx, ry, rnv, rnx);
         send(rx, ry, rnv, rnx, 1'b1);
      end
      wait_drain();

      // Backpressure: two accepts fill the pipe, then in_ready drops and out_y holds.
      out_ready = 1'b0;
      pop_log.delete();
      base    = acc_total;
      have    = 1'b0;
      dropped = 1'b0;
      held    = 32'd0;
      fork
         begin
            send(32'h4120_0000, 32'd10, 1'b0, 1'b0, 1'b0);
            send(32'hC1A0_0000, 32'hFFFF_FFEC, 1'b0, 1'b0, 1'b0);
            send(32'h4240_0000, 32'd48, 1'b0, 1'b0, 1'b0);
            send(32'h42C8_0000, 32'd100, 1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (5) begin
               @(negedge clk);
               if (out_valid) begin
                  if (!have) begin
                     held = out_y;
                     have = 1'b1;
                  end else begin
                     check("stall_hold_y", 64'(out_y), 64'(held));
                  end
               end
               if (!in_ready && !dropped) begin
                  dropped = 1'b1;
                  check("accepts_before_full", 64'(acc_total - base), 64'd2);
               end
            end
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_ready_dropped", 64'(dropped), 64'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check("bp_pop_count", 64'(pop_log.size()), 64'd4);
      if (pop_log.size() == 4)
         check("bp_consecutive", 64'(pop_log[3] - pop_log[0]), 64'd3);

      // Flush with both stages full and an operand offered in the flush cycle.
      out_ready = 1'b0;
      send(32'h4040_0000, 32'd3, 1'b0, 1'b0, 1'b0);
      send(32'h4080_0000, 32'd4, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_x     = 32'h40A0_0000;
      in_tag   = tag_ctr;
      flush    = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(32'h40C0_0000, 32'd6, 1'b0, 1'b0, 1'b1);
      wait_drain();

      // Asynchronous reset between edges with the pipe full.
      out_ready = 1'b0;
      send(32'h40E0_0000, 32'd7, 1'b0, 1'b0, 1'b0);
      send(32'h4100_0000, 32'd8, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("prereset_out_valid", 64'(out_valid), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_out_y", 64'(out_y), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      send(32'h4110_0000, 32'd9, 1'b0, 1'b0, 1'b1);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
